tick_rate_controller: RTL and testbench

//   Programmable rate controller that sequences the divided-clock domain of the LFSR design.

---
 rtl/tick_rate_controller_if.sv | 30 +++
 rtl/tick_rate_controller.sv | 165 ++++++++++++++++
 tb/tb_tick_rate_controller.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_rate_controller_if.sv
// Config channel of the tick rate controller: one valid/ready transfer carries mode, divisor and burst length.
// Latency: none, wires only.
// Backpressure: the controller lowers cfg_ready while a reconfiguration is waiting for a period boundary.
//
// Ports (modport slave = controller side):
//   cfg_valid      requester has a config word
//   cfg_ready      controller accepts this cycle
//   cfg_mode       0=STOP 1=RUN 2=BURST 3=reserved (acts as STOP)
//   cfg_divisor    period in clk cycles, 0 acts as 1
//   cfg_burst_len  ticks per burst
interface tick_rate_controller_if #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_mode;
  logic [CNT_W-1:0]   cfg_divisor;
  logic [BURST_W-1:0] cfg_burst_len;

  modport master (
    output cfg_valid, cfg_mode, cfg_divisor, cfg_burst_len,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_divisor, cfg_burst_len,
    output cfg_ready
  );
endinterface

// File: rtl/tick_rate_controller.sv
// Rate controller: emits a one-cycle tick enable every D clk cycles in RUN or BURST mode (no derived clocks).
// Latency: first tick D cycles after the accepting edge, then every D cycles; done one cycle after the last burst tick.
// Backpressure: cfg_ready low only while a RUN/BURST reconfiguration is staged and waiting for the end of the current tick cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg            config channel (slave modport), see tick_rate_controller_if
//   tick           registered one-cycle enable, one per period
//   tick_count     ticks since the last start from IDLE, wraps
//   busy           high in RUN or BURST
//   done           one-cycle pulse when a burst completes
module tick_rate_controller #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tick_rate_controller_if.slave     cfg,
  output logic                      tick,
  output logic [CNT_W-1:0]          tick_count,
  output logic                      busy,
  output logic                      done
);

  localparam logic [1:0]         MODE_RUN   = 2'd1;
  localparam logic [1:0]         MODE_BURST = 2'd2;
  localparam logic [CNT_W-1:0]   CNT_ONE    = 1;
  localparam logic [BURST_W-1:0] BURST_ONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Divisor is held as D-1 so D = 2^CNT_W-1 never needs a wider compare.
  typedef struct packed {
    logic [1:0]         mode;
    logic [CNT_W-1:0]   d_m1;
    logic [BURST_W-1:0] len;
  } cfg_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   dm1_q, dm1_d;
  logic [CNT_W-1:0]   tick_count_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  cfg_t               stg_q, stg_d, req;
  logic               stg_vld_q, stg_vld_d;
  logic               tick_d, done_d;
  logic               xfer, req_go;

  assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
  assign req_go = xfer && (cfg.cfg_mode == MODE_RUN || cfg.cfg_mode == MODE_BURST);

  always_comb begin
    req.mode = cfg.cfg_mode;
    req.d_m1 = (cfg.cfg_divisor == '0) ? '0 : cfg.cfg_divisor - CNT_ONE;
    req.len  = cfg.cfg_burst_len;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dm1_q      <= '0;
      rem_q      <= '0;
      stg_q      <= '0;
      stg_vld_q  <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm1_q      <= dm1_d;
      rem_q      <= rem_d;
      stg_q      <= stg_d;
      stg_vld_q  <= stg_vld_d;
      tick       <= tick_d;
      tick_count <= tick_count_d;
      done       <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d      = state_q;
    dm1_d        = dm1_q;
    rem_d        = rem_q;
    stg_d        = stg_q;
    stg_vld_d    = stg_vld_q;
    done_d       = 1'b0;
    cnt_d        = (cnt_q == dm1_q) ? '0 : cnt_q + CNT_ONE;
    tick_count_d = tick ? tick_count + CNT_ONE : tick_count;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_go) begin
          if (req.mode == MODE_RUN) begin
            state_d      = ST_RUN;
            dm1_d        = req.d_m1;
            tick_count_d = '0;
          end else if (req.len != '0) begin
            state_d      = ST_BURST;
            dm1_d        = req.d_m1;
            rem_d        = req.len;
            tick_count_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      default: begin
        if (xfer && !req_go) begin
          // STOP or reserved: abort on this edge, pending reconfig discarded.
          state_d   = ST_IDLE;
          cnt_d     = '0;
          stg_vld_d = 1'b0;
        end else begin
          if (req_go) begin
            stg_d     = req;
            stg_vld_d = 1'b1;
          end
          // tick high means this cycle closes a period: the only safe point to reconfigure.
          if (tick) begin
            if (stg_vld_q) begin
              stg_vld_d = 1'b0;
              cnt_d     = '0;
              dm1_d     = stg_q.d_m1;
              if (stg_q.mode == MODE_RUN) begin
                state_d = ST_RUN;
              end else if (stg_q.len != '0) begin
                state_d = ST_BURST;
                rem_d   = stg_q.len;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else if (state_q == ST_BURST) begin
              if (rem_q == BURST_ONE) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
              end else begin
                rem_d = rem_q - BURST_ONE;
              end
            end
          end
        end
      end
    endcase

    // Registered tick: high in the cycle where the counter reaches D-1.
    tick_d = (state_d != ST_IDLE) && (cnt_d == dm1_d);
  end

  // Outputs
  assign busy          = (state_q != ST_IDLE);
  assign cfg.cfg_ready = (state_q == ST_IDLE) || !stg_vld_q;

endmodule

// File: tb/tb_tick_rate_controller.sv
// Scoreboard bench for tick_rate_controller, built with CNT_W=4 so counter wrap and the maximum divisor are reachable.
// Latency: n/a.
// Backpressure: n/a.
module tb_tick_rate_controller;
  localparam int CNT_W   = 4;
  localparam int BURST_W = 8;
  localparam logic [1:0] M_STOP  = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_BURST = 2'd2;
  localparam logic [1:0] M_RSV   = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] tick_count;
  logic             busy;
  logic             done;

  tick_rate_controller_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) cfg_if ();

  tick_rate_controller #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg_if.slave),
    .tick       (tick),
    .tick_count (tick_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // cyc at a negedge is the index of the current cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit t;
    bit d;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic void push_ev(input int c, input bit t, input bit d);
    ev_t e;
    e.cyc = c;
    e.t   = t;
    e.d   = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: every tick/done the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event actual=none required=cyc%0d tick=%0b done=%0b", mon_e.cyc, mon_e.t, mon_e.d);
      end
      if (tick === 1'b1 || done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event actual=cyc%0d tick=%0b done=%0b required=none", cyc, tick, done);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.t != tick || mon_e.d != done) begin
            errors++;
            $display("FAIL event actual=cyc%0d tick=%0b done=%0b required=cyc%0d tick=%0b done=%0b",
                     cyc, tick, done, mon_e.cyc, mon_e.t, mon_e.d);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge with cfg_ready expected high; returns at the negedge of cycle 1.
  task automatic do_cfg(input logic [1:0] m, input int div, input int len, input string name);
    cfg_if.cfg_mode      = m;
    cfg_if.cfg_divisor   = div[CNT_W-1:0];
    cfg_if.cfg_burst_len = len[BURST_W-1:0];
    cfg_if.cfg_valid     = 1'b1;
    chk({name, "_ready"}, {31'd0, cfg_if.cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    cfg_if.cfg_valid     = 1'b0;
    cfg_if.cfg_mode      = M_STOP;
    cfg_if.cfg_divisor   = '0;
    cfg_if.cfg_burst_len = '0;

    #3;
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_tick_count", {28'd0, tick_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);

    // RUN D=4: ticks in cycles 4, 8, 12
    c1 = cyc + 1;
    push_ev(c1 + 3, 1, 0);
    push_ev(c1 + 7, 1, 0);
    push_ev(c1 + 11, 1, 0);
    do_cfg(M_RUN, 4, 0, "run4");
    wait_cyc(c1 + 11);
    chk("run4_busy", {31'd0, busy}, 32'd1);
    wait_cyc(c1 + 12);
    chk("run4_count", {28'd0, tick_count}, 32'd3);
    do_cfg(M_STOP, 0, 0, "run4_stop");
    chk("run4_stop_busy", {31'd0, busy}, 32'd0);

    // BURST D=3 len=2: ticks 3, 6; done 7
    c1 = cyc + 1;
    push_ev(c1 + 2, 1, 0);
    push_ev(c1 + 5, 1, 0);
    push_ev(c1 + 6, 0, 1);
    do_cfg(M_BURST, 3, 2, "burst");
    chk("burst_count_cleared", {28'd0, tick_count}, 32'd0);
    wait_cyc(c1 + 5);
    chk("burst_busy_last", {31'd0, busy}, 32'd1);
    wait_cyc(c1 + 6);
    chk("burst_busy_done", {31'd0, busy}, 32'd0);
    chk("burst_count", {28'd0, tick_count}, 32'd2);

    // RUN D=5, staged RUN D=2 in cycle 2: tick 5, then 7, 9
    c1 = cyc + 1;
    push_ev(c1 + 4, 1, 0);
    push_ev(c1 + 6, 1, 0);
    push_ev(c1 + 8, 1, 0);
    do_cfg(M_RUN, 5, 0, "stage_first");
    wait_cyc(c1 + 1);
    do_cfg(M_RUN, 2, 0, "stage_second");
    chk("stage_ready_c3", {31'd0, cfg_if.cfg_ready}, 32'd0);
    wait_cyc(c1 + 3);
    chk("stage_ready_c4", {31'd0, cfg_if.cfg_ready}, 32'd0);
    wait_cyc(c1 + 4);
    chk("stage_ready_c5", {31'd0, cfg_if.cfg_ready}, 32'd0);
    wait_cyc(c1 + 5);
    chk("stage_ready_c6", {31'd0, cfg_if.cfg_ready}, 32'd1);
    wait_cyc(c1 + 8);
    do_cfg(M_STOP, 0, 0, "stage_stop");
    chk("stage_count_kept", {28'd0, tick_count}, 32'd3);
    chk("stage_stop_busy", {31'd0, busy}, 32'd0);

    // RUN D=0 acts as D=1; STOP in cycle 3
    c1 = cyc + 1;
    push_ev(c1, 1, 0);
    push_ev(c1 + 1, 1, 0);
    push_ev(c1 + 2, 1, 0);
    do_cfg(M_RUN, 0, 0, "div0");
    wait_cyc(c1 + 2);
    do_cfg(M_STOP, 0, 0, "div0_stop");
    chk("div0_stop_tick", {31'd0, tick}, 32'd0);
    chk("div0_stop_busy", {31'd0, busy}, 32'd0);

    // BURST len=0 from IDLE: done in cycle 1, no tick
    c1 = cyc + 1;
    push_ev(c1, 0, 1);
    do_cfg(M_BURST, 3, 0, "len0");
    chk("len0_busy", {31'd0, busy}, 32'd0);
    wait_cyc(c1 + 3);
    chk("len0_busy_later", {31'd0, busy}, 32'd0);

    // Reserved mode in IDLE: no effect
    do_cfg(M_RSV, 2, 0, "rsv");
    wait_cyc(cyc + 4);
    chk("rsv_busy", {31'd0, busy}, 32'd0);

    // Largest divisor 2^CNT_W-1 = 15, one-tick burst
    c1 = cyc + 1;
    push_ev(c1 + 14, 1, 0);
    push_ev(c1 + 15, 0, 1);
    do_cfg(M_BURST, 15, 1, "maxdiv");
    wait_cyc(c1 + 13);
    chk("maxdiv_busy", {31'd0, busy}, 32'd1);
    wait_cyc(c1 + 15);
    chk("maxdiv_busy_done", {31'd0, busy}, 32'd0);

    // RUN D=1 for 17 cycles: tick_count wraps 15 -> 0
    c1 = cyc + 1;
    for (int k = 0; k < 17; k++) push_ev(c1 + k, 1, 0);
    do_cfg(M_RUN, 1, 0, "wrap");
    wait_cyc(c1 + 15);
    chk("wrap_count15", {28'd0, tick_count}, 32'd15);
    wait_cyc(c1 + 16);
    chk("wrap_count0", {28'd0, tick_count}, 32'd0);
    do_cfg(M_STOP, 0, 0, "wrap_stop");
    chk("wrap_stop_count", {28'd0, tick_count}, 32'd1);

    // Asynchronous reset in the middle of RUN
    c1 = cyc + 1;
    push_ev(c1, 1, 0);
    push_ev(c1 + 1, 1, 0);
    push_ev(c1 + 2, 1, 0);
    do_cfg(M_RUN, 1, 0, "arst");
    wait_cyc(c1 + 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tick", {31'd0, tick}, 32'd0);
    chk("arst_tick_count", {28'd0, tick_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("arst_busy_after", {31'd0, busy}, 32'd0);
    chk("arst_ready_after", {31'd0, cfg_if.cfg_ready}, 32'd1);

    wait_cyc(cyc + 2);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
